// File: rtl/mmio_uart_tx_if.sv
// Store-bus snoop interface carrying the CPU memory-stage write outputs.
interface mmio_uart_tx_if;
  logic        MemWriteM;
  logic [31:0] DataAdrM;
  logic [31:0] WriteDataM;

  modport master (output MemWriteM, DataAdrM, WriteDataM);
  modport slave  (input  MemWriteM, DataAdrM, WriteDataM);
endinterface

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: stores to UART_ADDR feed a TX FIFO that
// a registered-output serialiser drains onto tx.
module mmio_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter logic [31:0] UART_ADDR    = 32'h0000_00F0,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic          clk,
  input  logic          reset,
  mmio_uart_tx_if.slave bus,
  output logic          tx,
  output logic          busy,
  output logic          fifo_full,
  output logic          overflow
);

  localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // previous-cycle store snapshot
  logic        prev_we;
  logic [31:0] prev_adr;
  logic [31:0] prev_data;

  // FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic          hit, push, pop, drop;
  logic [7:0]    head;

  // serialiser
  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          tx_n;
  logic          bit_end;

  // A held strobe with unchanged address/data is one store, not many.
  assign hit = bus.MemWriteM && (bus.DataAdrM == UART_ADDR) &&
               (!prev_we || ({bus.DataAdrM, bus.WriteDataM} != {prev_adr, prev_data}));

  assign fifo_full = (count == C_FULL);
  assign busy      = (state != IDLE) || (count != '0);
  assign head      = mem[rd_ptr];
  assign push      = hit && (!fifo_full || pop);
  assign drop      = hit && fifo_full && !pop;
  assign bit_end   = (timer == T_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_we   <= 1'b0;
      prev_adr  <= '0;
      prev_data <= '0;
    end else begin
      prev_we   <= bus.MemWriteM;
      prev_adr  <= bus.DataAdrM;
      prev_data <= bus.WriteDataM;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.WriteDataM[7:0];
  end

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_n;
      if (drop) overflow <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    bit_n   = bit_idx;
    shift_n = shift;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          shift_n = head;
          timer_n = '0;
          bit_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (bit_end) begin
          timer_n = '0;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_n = '0;
          shift_n = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_n = '0;
          if (count != '0) begin
            pop     = 1'b1;
            shift_n = head;
            bit_n   = '0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          timer_n = timer + TW'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // tx is registered from the next-state view so the line changes on the edge itself
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      timer   <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      timer   <= timer_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4 and a negedge line receiver.
module tb_mmio_uart_tx;
  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic reset;
  logic tx, busy, fifo_full, overflow;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .UART_ADDR   (32'h0000_00F0),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .tx       (tx),
    .busy     (busy),
    .fifo_full(fifo_full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Line receiver: start detected on a low sample, bits sampled mid-period.
  logic [7:0]  rx_q[$];
  int unsigned rx_starts = 0;
  int unsigned rx_ferr   = 0;

  initial begin : rx_mon
    bit          active;
    int unsigned cnt;
    logic [7:0]  sh;
    active = 0;
    cnt    = 0;
    sh     = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        active = 0;
      end else if (!active) begin
        if (tx === 1'b0) begin
          active = 1;
          cnt    = 0;
          rx_starts++;
        end
      end else begin
        cnt++;
        if (cnt == 2 && tx !== 1'b0) rx_ferr++;
        if ((cnt % CPB) == 2 && cnt / CPB >= 1 && cnt / CPB <= 8) sh[cnt / CPB - 1] = tx;
        if (cnt == 9 * CPB + 2 && tx !== 1'b1) rx_ferr++;
        if (cnt == 10 * CPB - 1) begin
          rx_q.push_back(sh);
          active = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] adr, input logic [31:0] data);
    bus.MemWriteM  = we;
    bus.DataAdrM   = adr;
    bus.WriteDataM = data;
  endtask

  // Entered at the sample where the start bit should already be on the line.
  task automatic frame_check(input string tag, input logic [7:0] data);
    logic [9:0] fr;
    fr = {1'b1, data, 1'b0};
    for (int i = 0; i < 10 * CPB; i++) begin
      check(tag, tx, fr[i / CPB]);
      tick();
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int unsigned base_starts;
    int unsigned base_q;
    int unsigned bad;
    int unsigned waited;
    logic [9:0]  fr;

    reset = 1'b1;
    drive(1'b0, '0, '0);
    repeat (3) tick();
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_full", fifo_full, 0);
    check("rst_ovf", overflow, 0);
    reset = 1'b0;
    tick();
    check("post_rst_tx", tx, 1);
    check("post_rst_busy", busy, 0);

    // single byte, exact timing
    drive(1'b1, 32'h0000_00F0, 32'h0000_0041);
    tick();
    drive(1'b0, 32'h0000_00F0, 32'h0000_0041);
    check("single_pre_tx", tx, 1);
    check("single_pre_busy", busy, 1);
    tick();
    frame_check("single_frame", 8'h41);
    check("single_end_tx", tx, 1);
    check("single_end_busy", busy, 0);

    // held strobe
    base_starts = rx_starts;
    base_q      = rx_q.size();
    drive(1'b1, 32'h0000_00F0, 32'h0000_0055);
    repeat (10) tick();
    drive(1'b0, '0, '0);
    repeat (50) tick();
    check("held_frames", rx_starts - base_starts, 1);
    check("held_rx_count", rx_q.size() - base_q, 1);
    if (rx_q.size() > base_q) check("held_rx_byte", rx_q[rx_q.size() - 1], 8'h55);
    check("held_busy", busy, 0);

    // address filter
    drive(1'b1, 32'h0000_00F4, 32'h0000_0012);
    tick();
    drive(1'b1, 32'h0000_0000, 32'h0000_0034);
    tick();
    drive(1'b0, '0, '0);
    bad = 0;
    repeat (20) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("filter_quiet_cycles", bad, 0);
    check("filter_full", fifo_full, 0);

    // back-to-back frames
    drive(1'b1, 32'h0000_00F0, 32'h0000_0001);
    tick();
    drive(1'b1, 32'h0000_00F0, 32'h0000_0002);
    tick();
    drive(1'b0, '0, '0);
    frame_check("b2b_frame1", 8'h01);
    frame_check("b2b_frame2", 8'h02);
    check("b2b_end_tx", tx, 1);
    check("b2b_end_busy", busy, 0);

    // overflow
    rx_q.delete();
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 32'h0000_00F0, 32'h0000_00A0 + i);
      tick();
      if (i == 15) check("ovf_not_full_15", fifo_full, 0);
      if (i == 16) begin
        check("ovf_full_17", fifo_full, 1);
        check("ovf_clear_17", overflow, 0);
      end
    end
    drive(1'b0, '0, '0);
    check("ovf_set", overflow, 1);
    check("ovf_full_18", fifo_full, 1);
    waited = 0;
    while (busy && waited < 17 * 10 * CPB + 100) begin
      tick();
      waited++;
    end
    check("ovf_drain_timeout", busy, 0);
    repeat (2) tick();
    check("ovf_frames", rx_q.size(), 17);
    for (int k = 0; k < 17; k++) begin
      if (k < rx_q.size()) check($sformatf("ovf_byte%0d", k), rx_q[k], 8'hA0 + k);
    end
    check("ovf_sticky", overflow, 1);
    check("ovf_end_full", fifo_full, 0);
    check("framing_errors", rx_ferr, 0);

    // reset during data bit 3 with another byte queued
    drive(1'b1, 32'h0000_00F0, 32'h0000_003C);
    tick();
    drive(1'b1, 32'h0000_00F0, 32'h0000_00C3);
    tick();
    drive(1'b0, '0, '0);
    repeat (17) tick();
    fr = {1'b1, 8'h3C, 1'b0};
    check("mid_bit3_tx", tx, fr[4]);
    check("mid_busy", busy, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_tx", tx, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_ovf", overflow, 0);
    check("async_rst_full", fifo_full, 0);
    repeat (2) tick();
    reset = 1'b0;
    base_starts = rx_starts;
    bad = 0;
    repeat (60) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0) bad++;
    end
    check("post_abort_frames", rx_starts - base_starts, 0);
    check("post_abort_quiet", bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
